// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: producer-side hazard tracking for the 5-stage MIPS pipeline.
// Holds {A3, RegWrite, Tnew} for every in-flight producer in E/M/W, compares
// them against the D-stage consumer's Tuse, and owns the HI/LO busy counter.
//
// Stall semantics: stall is a pure combinational OR of the rs, rt and md
// terms. While stall=1 the upstream pipeline holds PC and F/D, and this block
// injects an all-zero bubble into the E slot. The D instruction is accepted
// on the first rising edge where stall=0.
module hazard_stall_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_A1,
  input  logic [4:0] D_A2,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_A3,
  input  logic       D_RegWrite,
  input  logic [1:0] D_Tnew,
  input  logic       D_md_use,
  input  logic       D_md_start,
  input  logic       D_md_div,
  output logic       stall,
  output logic [4:0] E_A3,
  output logic [4:0] M_A3,
  output logic [4:0] W_A3,
  output logic       E_RegWrite,
  output logic       M_RegWrite,
  output logic       W_RegWrite,
  output logic       md_busy
);

  typedef struct packed {
    logic [4:0] a3;
    logic       rw;
    logic [1:0] tnew;
  } slot_t;

  localparam slot_t SLOT_CLEAR = '{a3: 5'd0, rw: 1'b0, tnew: 2'd0};

  slot_t            e_q, e_d;
  slot_t            m_q, m_d;
  // W keeps only A3/RegWrite: its Tnew is always 0 and never feeds a stall.
  logic [4:0]       w_a3_q, w_a3_d;
  logic             w_rw_q, w_rw_d;
  logic             e_md_start_q, e_md_start_d;
  logic             e_md_div_q, e_md_div_d;
  logic [CNT_W-1:0] busy_q, busy_d;

  logic             stall_rs;
  logic             stall_rt;
  logic             stall_md;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // True when an operand read at Tuse cannot be satisfied by forwarding from E or M.
  function automatic logic src_hazard(input logic [4:0] a, input logic [1:0] tuse,
                                      input slot_t e, input slot_t m);
    logic hit_e;
    logic hit_m;
    hit_e = e.rw && (e.a3 == a) && (e.tnew > tuse);
    hit_m = m.rw && (m.a3 == a) && (m.tnew > tuse);
    return (a != 5'd0) && (tuse != 2'd3) && (hit_e || hit_m);
  endfunction

  // Stall decision: single OR of all causes, no memory between cycles.
  always_comb begin
    stall_rs = src_hazard(D_A1, D_Tuse_rs, e_q, m_q);
    stall_rt = src_hazard(D_A2, D_Tuse_rt, e_q, m_q);
    stall_md = D_md_use && ((busy_q != '0) || e_md_start_q);
    stall    = stall_rs || stall_rt || stall_md;
  end

  // Next-state for the slot shift and the busy counter.
  always_comb begin
    e_d          = SLOT_CLEAR;
    e_md_start_d = 1'b0;
    e_md_div_d   = 1'b0;
    if (!stall) begin
      // $0 is never reported as a producer; A3 is zeroed when nothing is written.
      e_d.a3       = (D_RegWrite && (D_A3 != 5'd0)) ? D_A3 : 5'd0;
      e_d.rw       = D_RegWrite;
      e_d.tnew     = D_Tnew;
      e_md_start_d = D_md_start;
      e_md_div_d   = D_md_start && D_md_div;
    end

    m_d      = e_q;
    m_d.tnew = dec_sat(e_q.tnew);
    w_a3_d   = m_q.a3;
    w_rw_d   = m_q.rw;

    if (e_md_start_q) begin
      busy_d = e_md_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (busy_q != '0) begin
      busy_d = busy_q - CNT_W'(1);
    end else begin
      busy_d = '0;
    end
  end

  // State registers; reset clears every slot and the busy counter on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q          <= SLOT_CLEAR;
      m_q          <= SLOT_CLEAR;
      w_a3_q       <= 5'd0;
      w_rw_q       <= 1'b0;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
      busy_q       <= '0;
    end else begin
      e_q          <= e_d;
      m_q          <= m_d;
      w_a3_q       <= w_a3_d;
      w_rw_q       <= w_rw_d;
      e_md_start_q <= e_md_start_d;
      e_md_div_q   <= e_md_div_d;
      busy_q       <= busy_d;
    end
  end

  assign E_A3       = e_q.a3;
  assign E_RegWrite = e_q.rw;
  assign M_A3       = m_q.a3;
  assign M_RegWrite = m_q.rw;
  assign W_A3       = w_a3_q;
  assign W_RegWrite = w_rw_q;
  assign md_busy    = (busy_q != '0);

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against an in-bench model that
// tracks in-flight instructions and the HI/LO free time as an absolute cycle.
module tb_hazard_stall_unit;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_A1, D_A2, D_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic       D_RegWrite, D_md_use, D_md_start, D_md_div;
  logic       stall, md_busy;
  logic [4:0] E_A3, M_A3, W_A3;
  logic       E_RegWrite, M_RegWrite, W_RegWrite;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk(clk), .reset(reset),
    .D_A1(D_A1), .D_A2(D_A2), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_A3(D_A3), .D_RegWrite(D_RegWrite), .D_Tnew(D_Tnew),
    .D_md_use(D_md_use), .D_md_start(D_md_start), .D_md_div(D_md_div),
    .stall(stall),
    .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
    .E_RegWrite(E_RegWrite), .M_RegWrite(M_RegWrite), .W_RegWrite(W_RegWrite),
    .md_busy(md_busy)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each in-flight instruction carries its remaining cycles-to-result.
  typedef struct {
    logic [4:0] a3;
    logic       rw;
    int         tnew;
    logic       mds;
    logic       mdd;
  } ent_t;

  ent_t me, mm, mw;
  int   cyc = 0;
  int   busy_until = 0;   // HI/LO busy while cyc < busy_until
  bit   chk_en = 1'b0;

  function automatic bit reg_late(input logic [4:0] a, input logic [1:0] tuse);
    int need;
    need = int'(tuse);
    if (a == 5'd0 || need == 3) return 1'b0;
    if (me.rw && me.a3 == a && me.tnew > need) return 1'b1;
    if (mm.rw && mm.a3 == a && mm.tnew > need) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    bit hilo_blocked;
    hilo_blocked = (cyc < busy_until) || me.mds;
    return reg_late(D_A1, D_Tuse_rs) || reg_late(D_A2, D_Tuse_rt) ||
           (D_md_use && hilo_blocked);
  endfunction

  function automatic logic [4:0] shown_a3(input ent_t x);
    return (x.rw && x.a3 != 5'd0) ? x.a3 : 5'd0;
  endfunction

  // Model advance on each edge, from pre-edge model state and D inputs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      me         <= '{5'd0, 1'b0, 0, 1'b0, 1'b0};
      mm         <= '{5'd0, 1'b0, 0, 1'b0, 1'b0};
      mw         <= '{5'd0, 1'b0, 0, 1'b0, 1'b0};
      busy_until <= 0;
      chk_en     <= 1'b1;
    end else begin
      if (me.mds) busy_until <= cyc + 1 + (me.mdd ? 10 : 5);
      mw <= '{mm.a3, mm.rw, (mm.tnew > 0) ? mm.tnew - 1 : 0, 1'b0, 1'b0};
      mm <= '{me.a3, me.rw, (me.tnew > 0) ? me.tnew - 1 : 0, 1'b0, 1'b0};
      if (model_stall()) me <= '{5'd0, 1'b0, 0, 1'b0, 1'b0};
      else               me <= '{D_A3, D_RegWrite, int'(D_Tnew), D_md_start, D_md_div};
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("E_A3", E_A3, shown_a3(me));
      cmp("M_A3", M_A3, shown_a3(mm));
      cmp("W_A3", W_A3, shown_a3(mw));
      cmp("E_RegWrite", E_RegWrite, me.rw);
      cmp("M_RegWrite", M_RegWrite, mm.rw);
      cmp("W_RegWrite", W_RegWrite, mw.rw);
      cmp("stall", stall, model_stall());
      cmp("md_busy", md_busy, cyc < busy_until);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic d_set(input logic [4:0] a1, input logic [1:0] tr,
                       input logic [4:0] a2, input logic [1:0] tt,
                       input logic [4:0] a3, input logic rw, input logic [1:0] tn,
                       input logic mu, input logic ms, input logic md);
    D_A1 = a1; D_Tuse_rs = tr; D_A2 = a2; D_Tuse_rt = tt;
    D_A3 = a3; D_RegWrite = rw; D_Tnew = tn;
    D_md_use = mu; D_md_start = ms; D_md_div = md;
  endtask

  task automatic d_nop();
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive stalled cycles (bounded) with the current D inputs held.
  task automatic count_stall(output int n, output int nb);
    n  = 0;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (!stall) break;
      n++;
      if (md_busy) nb++;
      @(posedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, nb;
    reset = 1'b1;
    d_nop();
    tick(); tick();
    reset = 1'b0;

    // Reset state
    cmp("rst E_A3", E_A3, 0);
    cmp("rst W_RegWrite", W_RegWrite, 0);
    cmp("rst md_busy", md_busy, 0);
    cmp("rst stall", stall, 0);

    // Load-use: lw $8 then addu rs=$8
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    #1 cmp("lu pre stall", stall, 0);
    tick();
    cmp("lu E_A3", E_A3, 8);
    d_set(5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    #1 cmp("lu stall", stall, 1);
    tick();
    cmp("lu bubble E_RegWrite", E_RegWrite, 0);
    cmp("lu M_A3", M_A3, 8);
    cmp("lu stall cleared", stall, 0);
    tick();
    cmp("lu addu E_A3", E_A3, 10);
    d_nop(); tick(); tick(); tick();

    // Branch after ALU producer
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    d_set(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    count_stall(n, nb);
    cmp("br-alu stall cycles", n, 1);
    d_nop(); tick(); tick(); tick();

    // Branch after load
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    d_set(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    count_stall(n, nb);
    cmp("br-lw stall cycles", n, 2);
    d_nop(); tick(); tick(); tick();

    // $0 producer and unused operand
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    cmp("r0 E_A3", E_A3, 0);
    d_set(5'd0, 2'd1, 5'd0, 2'd1, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    #1 cmp("r0 stall", stall, 0);
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    d_set(5'd0, 2'd3, 5'd5, 2'd3, 5'd6, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    #1 cmp("unused rt stall E", stall, 0);
    tick();
    cmp("unused rt stall M", stall, 0);
    d_nop(); tick(); tick(); tick();

    // Divide busy then mflo
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    count_stall(n, nb);
    cmp("div stall cycles", n, 11);
    cmp("div busy cycles", nb, 10);
    cmp("div busy after", md_busy, 0);
    d_nop(); tick(); tick(); tick();

    // Multiply busy then mflo
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    count_stall(n, nb);
    cmp("mult stall cycles", n, 6);
    cmp("mult busy cycles", nb, 5);
    d_nop(); tick(); tick(); tick();

    // Reset mid-divide with mflo waiting in D
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    cmp("mid-div busy", md_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("rst-div md_busy", md_busy, 0);
    cmp("rst-div E_A3", E_A3, 0);
    cmp("rst-div M_RegWrite", M_RegWrite, 0);
    cmp("rst-div W_A3", W_A3, 0);
    cmp("rst-div stall", stall, 0);
    d_nop(); tick(); tick(); tick();

    // Pipeline tracking
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    cmp("pipe E1", E_A3, 1);
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    cmp("pipe E2", E_A3, 2);
    cmp("pipe M1", M_A3, 1);
    d_set(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    cmp("pipe E3", E_A3, 3);
    cmp("pipe M2", M_A3, 2);
    cmp("pipe W1", W_A3, 1);
    cmp("pipe W_RegWrite", W_RegWrite, 1);
    d_nop();
    tick();
    cmp("pipe M3", M_A3, 3);
    cmp("pipe W2", W_A3, 2);
    tick();
    cmp("pipe W3", W_A3, 3);

    // Randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      reset      = ($urandom_range(0, 149) == 0);
      D_A1       = 5'($urandom_range(0, 3));
      D_A2       = 5'($urandom_range(0, 3));
      D_Tuse_rs  = 2'($urandom_range(0, 3));
      D_Tuse_rt  = 2'($urandom_range(0, 3));
      D_A3       = 5'($urandom_range(0, 3));
      D_RegWrite = 1'($urandom_range(0, 1));
      D_Tnew     = 2'($urandom_range(0, 2));
      D_md_start = ($urandom_range(0, 9) == 0);
      D_md_div   = 1'($urandom_range(0, 1));
      D_md_use   = D_md_start || ($urandom_range(0, 5) == 0);
    end

    reset = 1'b0;
    d_nop();
    repeat (15) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Producer-side hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W). The forwarding controller only chooses which in-flight result a consumer reads. This block tracks every in-flight producer: its destination, write-enable and remaining cycles-to-result (Tnew). It compares these against the D-stage consumer's Tuse and raises a stall when no forwarding path can supply the value in time. It also owns the HI/LO multiply/divide busy counter. It publishes per-stage A3/RegWrite for the forwarding controller.

Parameters:
MULT_CYCLES, 5, busy cycles loaded when a mult/multu leaves E
DIV_CYCLES, 10, busy cycles loaded when a div/divu leaves E
CNT_W, 4, busy-counter width; must hold DIV_CYCLES

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
D_A1  in  5  rs index of instruction in D
D_A2  in  5  rt index of instruction in D
D_Tuse_rs  in  2  cycles until D instr needs rs; 3 = rs unused
D_Tuse_rt  in  2  cycles until D instr needs rt; 3 = rt unused
D_A3  in  5  destination of instruction in D
D_RegWrite  in  1  D instr writes GRF
D_Tnew  in  2  Tnew on entry to E: 0 link, 1 ALU/mfhi/mflo, 2 load
D_md_use  in  1  D instr touches HI/LO (mult/div/mthi/mtlo/mfhi/mflo)
D_md_start  in  1  D instr is mult/multu/div/divu
D_md_div  in  1  with D_md_start: 1 = div/divu, 0 = mult/multu
stall  out  1  freeze PC and F/D register, bubble D/E register
E_A3, M_A3, W_A3  out  5 each  destination held in each stage slot
E_RegWrite, M_RegWrite, W_RegWrite  out  1 each  write-enable held in each stage slot
md_busy  out  1  busy counter nonzero

Behaviour:
- Internal slots E, M and W each hold {A3, RegWrite, Tnew}. The E slot additionally holds {md_start, md_div}. All slot outputs are registered.
- Reset, synchronous: all slots are cleared (A3=0, RegWrite=0, Tnew=0, md flags 0) and the busy counter is set to 0. While the slots are clear, stall=0 and md_busy=0. Reset in mid-operation, including during a divide, clears everything on that edge. No pending state survives reset.
- Every rising edge, when not in reset:
  - E slot loads from D when stall=0. When stall=1 it loads a bubble of all zeros.
  - M slot loads E, with Tnew decremented and saturating at 0.
  - W slot loads M in the same way.
- The slot outputs force A3=0 whenever RegWrite=0 or the loaded D_A3 was 0. Register $0 is never reported as a producer.
- stall is combinational and is the OR of the following terms:
  - rs term: D_A1≠0, D_Tuse_rs≠3, and either (E_RegWrite, E_A3==D_A1, E.Tnew>D_Tuse_rs) or (M_RegWrite, M_A3==D_A1, M.Tnew>D_Tuse_rs).
  - rt term: the same as the rs term, using D_A2 and D_Tuse_rt.
  - md term: D_md_use and (busy counter≠0 or E.md_start).
- The W slot never causes a stall, because its Tnew is always 0.
- Busy counter:
  - On an edge where E.md_start=1, it loads DIV_CYCLES if E.md_div=1, else MULT_CYCLES.
  - Otherwise it decrements while nonzero and holds at 0.
  - md_busy = (counter≠0).
- A stalled D md_start is not captured into E, so it cannot start twice or start early.
- Simultaneous causes: stall is a single OR. There is no priority between causes and no one-cycle memory; stall drops in the same cycle the last cause clears.
- Latency: D inputs reach the E_* outputs one edge after acceptance, M_* after two edges, and W_* after three edges.

Test Plan:
- Load-use: lw $8 (D_Tnew=2) then addu using $8 as rs (Tuse_rs=1) → stall=1 for exactly 1 cycle. Next cycle E slot is a bubble (E_RegWrite=0), M_A3=8, stall=0.
- Branch after ALU: addu $9 then beq on $9 (Tuse_rs=0) → stall for 1 cycle. Branch after lw $9 → stall for 2 cycles.
- $0 and unused operands: lw $0 then addu reading $0; separately, D_Tuse_rt=3 with D_A2 matching E_A3 → stall=0 throughout.
- Divide busy: div leaves E, then mflo in D on the next cycle → stall=1 for 11 cycles. One cycle is E.md_start, then 10 busy cycles. md_busy is high for 10 cycles. With mult, stall=1 for 6 cycles.
- Reset mid-divide: assert reset 3 cycles into div busy → next edge md_busy=0, all A3/RegWrite=0, stall=0 with mflo in D.
- Pipeline tracking: stream addu $1, $2, $3 with no stalls → E/M/W_A3 show 1,2,3 shifting one stage per edge. W_RegWrite=1 three edges after D acceptance.
